// File: rtl/distortion_pkg.sv
// Shared types, widths, reset constants and helpers for distortion_ctrl.
// Holds the FSM state enum, the gain step function and the symmetric clip.
package distortion_pkg;

  localparam int SMP_W          = 16;
  localparam int GAIN_W         = 8;
  localparam int PROD_W         = 24;
  localparam int THR_W          = 15;
  localparam int DIV_CYCLES_DEF = 24;

  localparam logic [GAIN_W-1:0] RST_NUM = 8'd1;
  localparam logic [GAIN_W-1:0] RST_DEN = 8'd1;
  localparam logic [THR_W-1:0]  RST_THR = 15'd32767;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_L,
    ST_DIV_L,
    ST_MUL_R,
    ST_DIV_R,
    ST_CLIP,
    ST_OUT
  } state_t;

  // Move the active gain one unit toward its target.
  function automatic logic [GAIN_W-1:0] step_toward(
    input logic [GAIN_W-1:0] a,
    input logic [GAIN_W-1:0] t
  );
    if (a < t) return a + 8'd1;
    else if (a > t) return a - 8'd1;
    return a;
  endfunction

  // q is full width, so saturation never sees a wrapped value.
  function automatic logic [SMP_W-1:0] clip_q(
    input logic signed [PROD_W:0] q,
    input logic [THR_W-1:0]       thr
  );
    logic signed [PROD_W:0] p;
    logic signed [PROD_W:0] n;
    p = $signed({10'd0, thr});
    n = -p;
    if (q > p) return p[SMP_W-1:0];
    else if (q < n) return n[SMP_W-1:0];
    return q[SMP_W-1:0];
  endfunction

endpackage

// File: rtl/distortion_div.sv
// Serial restoring divider, unsigned 24/8, one quotient bit per cycle.
// Ports: i_start loads operands; o_done is high during the final iteration; o_quot valid after it.
module distortion_div
  import distortion_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [PROD_W-1:0] i_dividend,
  input  logic [GAIN_W-1:0] i_divisor,
  output logic              o_done,
  output logic [PROD_W-1:0] o_quot
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [PROD_W-1:0] r_quot;
  logic [GAIN_W-1:0] r_rem;
  logic [GAIN_W-1:0] r_den;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;

  logic [GAIN_W:0]   w_trial;
  logic [GAIN_W:0]   w_sub;
  logic              w_ge;

  // Dividend bits shift out of the top of r_quot as quotient bits shift in.
  assign w_trial = {r_rem, r_quot[PROD_W-1]};
  assign w_sub   = w_trial - {1'b0, r_den};
  assign w_ge    = w_trial >= {1'b0, r_den};
  assign o_done  = r_busy && (r_cnt == CW'(DIV_CYCLES - 1));
  assign o_quot  = r_quot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quot <= i_dividend;
      r_rem  <= '0;
      r_den  <= i_divisor;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_ge ? w_sub[GAIN_W-1:0] : w_trial[GAIN_W-1:0];
      r_quot <= {r_quot[PROD_W-2:0], w_ge};
      r_cnt  <= r_cnt + 1'b1;
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/distortion_ctrl.sv
// Stereo gain (num/den) and symmetric clip with one shared multiplier and divider.
// Ports: in_valid/in_ready frame handshake, cfg_* targets, out_valid pulse, busy.
module distortion_ctrl
  import distortion_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [SMP_W-1:0] left_in,
  input  logic signed [SMP_W-1:0] right_in,
  output logic                    out_valid,
  output logic signed [SMP_W-1:0] left_out,
  output logic signed [SMP_W-1:0] right_out,
  input  logic                    cfg_we,
  input  logic [GAIN_W-1:0]       cfg_gain_num,
  input  logic [GAIN_W-1:0]       cfg_gain_den,
  input  logic [THR_W-1:0]        cfg_thresh,
  output logic                    busy
);

  state_t                 r_state;
  logic signed [SMP_W-1:0] r_left;
  logic signed [SMP_W-1:0] r_right;
  logic [GAIN_W-1:0]      r_act_num;
  logic [GAIN_W-1:0]      r_act_den;
  logic [THR_W-1:0]       r_act_thr;
  logic [GAIN_W-1:0]      r_tgt_num;
  logic [GAIN_W-1:0]      r_tgt_den;
  logic [THR_W-1:0]       r_tgt_thr;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [PROD_W:0] r_q_l;
  logic                   r_out_valid;
  logic [SMP_W-1:0]       r_left_out;
  logic [SMP_W-1:0]       r_right_out;

  logic signed [SMP_W-1:0]  w_smp;
  logic signed [PROD_W-1:0] w_smp_x;
  logic signed [PROD_W-1:0] w_num_x;
  logic signed [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0]        w_mag;
  logic                     w_start;
  logic                     w_done;
  logic [PROD_W-1:0]        w_quot;
  logic signed [PROD_W:0]   w_quot_s;
  logic signed [PROD_W:0]   w_q;

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = !in_ready;
  assign out_valid = r_out_valid;
  assign left_out  = r_left_out;
  assign right_out = r_right_out;

  // One multiplier: right sample only while in MUL_R.
  assign w_smp   = (r_state == ST_MUL_R) ? r_right : r_left;
  assign w_smp_x = {{(PROD_W-SMP_W){w_smp[SMP_W-1]}}, w_smp};
  assign w_num_x = {{(PROD_W-GAIN_W){1'b0}}, r_act_num};
  assign w_prod  = w_smp_x * w_num_x;
  assign w_mag   = w_prod[PROD_W-1] ? -w_prod : w_prod;
  assign w_start = (r_state == ST_MUL_L) || (r_state == ST_MUL_R);

  distortion_div #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_dividend (w_mag),
    .i_divisor  (r_act_den),
    .o_done     (w_done),
    .o_quot     (w_quot)
  );

  // r_prod still holds the channel whose quotient just finished.
  always_comb begin
    w_quot_s = $signed({1'b0, w_quot});
    if (r_prod[PROD_W-1]) w_quot_s = -w_quot_s;
    w_q = w_quot_s;
    if (r_act_den == 8'd0) w_q = {r_prod[PROD_W-1], r_prod};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tgt_num <= RST_NUM;
      r_tgt_den <= RST_DEN;
      r_tgt_thr <= RST_THR;
    end else if (cfg_we) begin
      r_tgt_num <= cfg_gain_num;
      r_tgt_den <= cfg_gain_den;
      r_tgt_thr <= cfg_thresh;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_left      <= '0;
      r_right     <= '0;
      r_act_num   <= RST_NUM;
      r_act_den   <= RST_DEN;
      r_act_thr   <= RST_THR;
      r_prod      <= '0;
      r_q_l       <= '0;
      r_out_valid <= 1'b0;
      r_left_out  <= '0;
      r_right_out <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_left    <= left_in;
            r_right   <= right_in;
            r_act_num <= step_toward(r_act_num, r_tgt_num);
            r_act_den <= r_tgt_den;
            r_act_thr <= r_tgt_thr;
            r_state   <= ST_MUL_L;
          end
        end
        ST_MUL_L: begin
          r_prod  <= w_prod;
          r_state <= ST_DIV_L;
        end
        ST_DIV_L: begin
          if (w_done) r_state <= ST_MUL_R;
        end
        ST_MUL_R: begin
          r_q_l   <= w_q;
          r_prod  <= w_prod;
          r_state <= ST_DIV_R;
        end
        ST_DIV_R: begin
          if (w_done) r_state <= ST_CLIP;
        end
        ST_CLIP: begin
          r_left_out  <= clip_q(r_q_l, r_act_thr);
          r_right_out <= clip_q(w_q, r_act_thr);
          r_out_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/distortion_ctrl.md
DISTORTION_CTRL -- requirements
Module: distortion_ctrl

Interface
REQ-001 Parameter: DIV_CYCLES, default 24, number of iterations of the serial divider (one per quotient bit).
REQ-002 Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  stereo frame available
- in_ready  out  1  block can accept a frame
- left_in, right_in  in  16 each  signed samples
- out_valid  out  1  one-cycle pulse; output frame valid
- left_out, right_out  out  16 each  signed processed samples
- cfg_we  in  1  load configuration targets
- cfg_gain_num  in  8  unsigned gain numerator, 0-128
- cfg_gain_den  in  8  unsigned gain denominator, 0-128
- cfg_thresh  in  15  unsigned symmetric clip level
- busy  out  1  frame in progress

Function
REQ-003 The block SHALL compute, per channel, q = (sample * num) / den, then clip q to [-thr, +thr], sharing one multiplier and one serial divider between channels.
REQ-004 in_ready SHALL equal (state == IDLE); a frame is accepted on an edge where in_valid and in_ready are both high; busy = !in_ready.
REQ-005 The FSM SHALL have states IDLE, MUL_L, DIV_L, MUL_R, DIV_R, CLIP, OUT. The sequence is accept (edge 0), MUL_L for 1 cycle, DIV_L for DIV_CYCLES cycles, MUL_R for 1 cycle, DIV_R for DIV_CYCLES cycles, CLIP for 1 cycle, OUT for 1 cycle, then IDLE.
REQ-006 out_valid SHALL be high only in OUT, exactly 2*DIV_CYCLES+4 cycles after the accepting edge (52 at default).
REQ-007 There is no output backpressure. left_out and right_out SHALL update only on entry to OUT and hold until the next OUT.
REQ-008 Width rules:
- The product SHALL be a 24-bit signed value (16-bit signed x 8-bit unsigned).
- The divider SHALL operate on magnitudes and restore the sign, truncating toward zero.
- The clip SHALL use full-width q, so no wrap-around is possible.
REQ-009 den == 0 SHALL bypass the divide (q = sample * num, treated as unity divide); the state sequence and latency SHALL be unchanged.
REQ-010 Clipping SHALL follow:
- q > thr gives +thr.
- q < -thr gives -thr.
- Otherwise the result is q[15:0].
- thr = 0 SHALL yield all-zero outputs.
REQ-011 cfg_we SHALL load target_num, target_den and target_thr on any cycle, in any state.
REQ-012 On each accepting edge:
- active_num SHALL step by 1 toward target_num; the stepped value is used for that frame.
- active_den and active_thr SHALL be copied from their targets.
- These values SHALL be frozen for the rest of the frame.
REQ-013 If cfg_we and a frame accept occur on the same edge, the frame SHALL use the pre-write targets; the new targets apply from the next accept.
REQ-014 in_valid asserted while busy SHALL be ignored; the frame is not latched.

Reset
REQ-015 On rst, the block SHALL set:
- state = IDLE, in_ready = 1, busy = 0, out_valid = 0
- left_out = right_out = 0
- active_num, target_num, active_den, target_den = 1
- active_thr, target_thr = 32767
- divider cleared
REQ-016 rst asserted mid-frame SHALL abort the frame; no out_valid is produced for that frame.

Structure
REQ-017 Package distortion_pkg SHALL hold the FSM state enum, sample/product widths, DIV_CYCLES default and the reset constants (num, den, thr).
REQ-018 One sub-module, distortion_div, SHALL implement the serial restoring divider (start/done, unsigned 24/8, DIV_CYCLES iterations); distortion_ctrl instantiates it once.

Verification
REQ-019 Defaults: after reset, frame (1000, -1000) -> out_valid at cycle 52 with (1000, -1000); in_ready high again at cycle 53.
REQ-020 Ramp and clip: cfg num=4, den=1, thr=24000, then three frames of (8000, -7000) -> (16000, -14000), (24000, -21000), (24000, -24000).
REQ-021 Truncation: num=1, den=3, frame (-5, 5) -> (-1, 1); frame (-32768, 32767) -> (-10922, 10922).
REQ-022 den=0, thr=32767: frame (30000, -32768) -> (30000, -32767).
REQ-023 Backpressure and collision: in_valid held high -> second frame accepted at edge 53. cfg_we on the accept edge -> new targets unused until the following frame.
REQ-024 Reset mid-frame: rst at cycle 30 -> no out_valid, outputs 0, in_ready = 1; the next frame is processed with gain 1/1.
